bit_reverse_reorder: RTL and testbench

BIT_REVERSE_REORDER -- requirements
Module: bit_reverse_reorder

---
 rtl/bit_reverse_reorder_if.sv | 26 ++
 rtl/bit_reverse_reorder.sv | 136 +++++++++++++
 tb/tb_bit_reverse_reorder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bit_reverse_reorder_if.sv
// Sample stream bus for the bit-reverse reorder buffer.
// The slave side is the reorder block, which consumes bit-reversed samples and
// produces natural-order samples. The master side is whatever feeds and drains it.
interface bit_reverse_reorder_if #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned LOG2N  = 5
);
  logic              valid_i;
  logic [DATA_W-1:0] data_in_r;
  logic [DATA_W-1:0] data_in_i;
  logic              valid_o;
  logic [DATA_W-1:0] data_out_r;
  logic [DATA_W-1:0] data_out_i;
  logic [LOG2N-1:0]  index_o;
  logic              sop_o;

  modport master (
    output valid_i, data_in_r, data_in_i,
    input  valid_o, data_out_r, data_out_i, index_o, sop_o
  );

  modport slave (
    input  valid_i, data_in_r, data_in_i,
    output valid_o, data_out_r, data_out_i, index_o, sop_o
  );
endinterface

// File: rtl/bit_reverse_reorder.sv
// Ping-pong reorder buffer turning bit-reversed FFT output into natural order.
// Samples are written at bitrev(wcnt) into the write bank. A full bank is then
// read linearly for N back-to-back cycles, and the outputs are registered.
module bit_reverse_reorder #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned LOG2N  = 5
) (
  input logic                  clk,
  input logic                  rst,
  bit_reverse_reorder_if.slave bus
);
  localparam int unsigned N = 1 << LOG2N;
  localparam int unsigned W = 2 * DATA_W;

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  // Bank storage is deliberately not reset.
  logic [W-1:0]      mem_q [2][N];
  logic [LOG2N-1:0]  wcnt_q, wcnt_d, waddr;
  logic [LOG2N-1:0]  rcnt_q, rcnt_d;
  logic              wbank_q, wbank_d;
  logic              rbank_q, rbank_d;
  logic [1:0]        full_q, full_d;
  state_e            state_q, state_d;
  logic              rd_en;
  logic [W-1:0]      rdata;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] out_r_q, out_r_d;
  logic [DATA_W-1:0] out_i_q, out_i_d;
  logic [LOG2N-1:0]  index_q, index_d;
  logic              sop_q, sop_d;

  // Write address is the write counter with all of its bits reversed.
  always_comb begin
    waddr = '0;
    for (int b = 0; b < int'(LOG2N); b++) begin
      waddr[b] = wcnt_q[int'(LOG2N) - 1 - b];
    end
  end

  // Writer and reader next state. Both touch full_d, so they share one process.
  always_comb begin
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    full_d  = full_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    state_d = state_q;
    rd_en   = 1'b0;

    if (bus.valid_i) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == LOG2N'(N - 1)) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (|full_q) begin
          state_d = StRead;
          rcnt_d  = '0;
          // The most recently completed bank sits opposite the write bank.
          rbank_d = full_q[~wbank_q] ? ~wbank_q : wbank_q;
        end
      end
      StRead: begin
        rd_en  = 1'b1;
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == LOG2N'(N - 1)) begin
          full_d[rbank_q] = 1'b0;
          if (full_q[~rbank_q]) begin
            rbank_d = ~rbank_q;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read port and output next state; outputs are forced to zero when not valid.
  always_comb begin
    rdata   = mem_q[rbank_q][rcnt_q];
    valid_d = rd_en;
    out_r_d = rd_en ? rdata[W-1:DATA_W] : '0;
    out_i_d = rd_en ? rdata[DATA_W-1:0] : '0;
    index_d = rd_en ? rcnt_q : '0;
    sop_d   = rd_en && (rcnt_q == '0);
  end

  // Sample storage write.
  always_ff @(posedge clk) begin
    if (bus.valid_i) begin
      mem_q[wbank_q][waddr] <= {bus.data_in_r, bus.data_in_i};
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      full_q  <= '0;
      rcnt_q  <= '0;
      rbank_q <= 1'b0;
      state_q <= StIdle;
      valid_q <= 1'b0;
      out_r_q <= '0;
      out_i_q <= '0;
      index_q <= '0;
      sop_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wbank_q <= wbank_d;
      full_q  <= full_d;
      rcnt_q  <= rcnt_d;
      rbank_q <= rbank_d;
      state_q <= state_d;
      valid_q <= valid_d;
      out_r_q <= out_r_d;
      out_i_q <= out_i_d;
      index_q <= index_d;
      sop_q   <= sop_d;
    end
  end

  assign bus.valid_o    = valid_q;
  assign bus.data_out_r = out_r_q;
  assign bus.data_out_i = out_i_q;
  assign bus.index_o    = index_q;
  assign bus.sop_o      = sop_q;
endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Directed bench for bit_reverse_reorder: single, back-to-back, gapped,
// mid-frame reset and idle scenarios, with a hand-computed vector table.
module tb_bit_reverse_reorder;
  localparam int DW = 17;
  localparam int LN = 5;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_reverse_reorder_if #(.DATA_W(DW), .LOG2N(LN)) bus ();

  bit_reverse_reorder #(.DATA_W(DW), .LOG2N(LN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int            bin;
    logic [DW-1:0] exp_r;
    logic [DW-1:0] exp_i;
  } vec_t;

  vec_t          tbl [8];
  logic [DW-1:0] cap_r [64];
  logic [DW-1:0] cap_i [64];
  int            first_cyc;
  int            t_last [2];

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.valid_o, bus.sop_o, bus.index_o, bus.data_out_r, bus.data_out_i});
  endfunction

  // Drive nsamp samples real=base+k, imag=-(base+k), with gap idle cycles after each.
  task automatic drive_frame(input int base, input int nsamp, input int gap, input int slot);
    for (int k = 0; k < nsamp; k++) begin
      bus.valid_i   = 1'b1;
      bus.data_in_r = DW'(base + k);
      bus.data_in_i = DW'(-(base + k));
      @(posedge clk); #1;
      t_last[slot]  = cyc;
      bus.valid_i   = 1'b0;
      bus.data_in_r = '0;
      bus.data_in_i = '0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Wait (bounded) for output, then check nframes*32 consecutive bins and the drop after.
  task automatic check_frames(input int nframes, input string tag);
    bit            found = 1'b0;
    logic [DW-1:0] er, ei;
    logic [4:0]    b;
    for (int w = 0; w < 300 && !found; w++) begin
      @(posedge clk); #1;
      if (bus.valid_o) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      first_cyc = -1;
      $display("FAIL %s timeout: got no valid_o expected output within 300 cycles", tag);
      return;
    end
    first_cyc = cyc;
    for (int n = 0; n < 32 * nframes; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      b  = 5'(n % 32);
      er = DW'((n / 32) * 64 + int'(bitrev5(b)));
      ei = -er;
      cap_r[n] = bus.data_out_r;
      cap_i[n] = bus.data_out_i;
      check($sformatf("%s bin %0d {valid,sop,index,r,i}", tag, n), out_vec(),
            64'({1'b1, (b == 5'd0), b, er, ei}));
    end
    @(posedge clk); #1;
    check($sformatf("%s after last bin", tag), out_vec(), 64'd0);
  endtask

  task automatic check_table(input string tag);
    for (int t = 0; t < 8; t++) begin
      check($sformatf("%s table bin %0d real", tag, tbl[t].bin), 64'(cap_r[tbl[t].bin]),
            64'(tbl[t].exp_r));
      check($sformatf("%s table bin %0d imag", tag, tbl[t].bin), 64'(cap_i[tbl[t].bin]),
            64'(tbl[t].exp_i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion by 200us");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{bin: 0,  exp_r: 17'd0,  exp_i: 17'h00000};
    tbl[1] = '{bin: 1,  exp_r: 17'd16, exp_i: 17'h1FFF0};
    tbl[2] = '{bin: 2,  exp_r: 17'd8,  exp_i: 17'h1FFF8};
    tbl[3] = '{bin: 3,  exp_r: 17'd24, exp_i: 17'h1FFE8};
    tbl[4] = '{bin: 4,  exp_r: 17'd4,  exp_i: 17'h1FFFC};
    tbl[5] = '{bin: 5,  exp_r: 17'd20, exp_i: 17'h1FFEC};
    tbl[6] = '{bin: 30, exp_r: 17'd15, exp_i: 17'h1FFF1};
    tbl[7] = '{bin: 31, exp_r: 17'd31, exp_i: 17'h1FFE1};

    rst           = 1'b1;
    bus.valid_i   = 1'b0;
    bus.data_in_r = '0;
    bus.data_in_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", out_vec(), 64'd0);
    rst = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      check($sformatf("idle cycle %0d", c), out_vec(), 64'd0);
    end

    // Single full-rate frame.
    fork
      drive_frame(0, 32, 0, 0);
      check_frames(1, "single");
    join
    check("single latency", 64'(first_cyc), 64'(t_last[0] + 2));
    check_table("single");
    repeat (5) @(posedge clk);
    #1;

    // Two back-to-back frames.
    fork
      begin
        drive_frame(0, 32, 0, 0);
        drive_frame(64, 32, 0, 1);
      end
      check_frames(2, "b2b");
    join
    check("b2b latency f0", 64'(first_cyc), 64'(t_last[0] + 2));
    check("b2b latency f1", 64'(first_cyc + 32), 64'(t_last[1] + 2));
    repeat (5) @(posedge clk);
    #1;

    // Gapped input, valid every other cycle.
    fork
      drive_frame(0, 32, 1, 0);
      check_frames(1, "gap");
    join
    check("gap latency", 64'(first_cyc), 64'(t_last[0] + 2));
    check_table("gap");
    repeat (5) @(posedge clk);
    #1;

    // Reset after 20 samples of a stale frame, then a clean frame.
    drive_frame(500, 20, 0, 0);
    rst = 1'b1;
    #1;
    check("mid-frame reset outputs", out_vec(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    fork
      drive_frame(0, 32, 0, 1);
      check_frames(1, "rst");
    join
    check("rst latency", 64'(first_cyc), 64'(t_last[1] + 2));
    check_table("rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
